// File: rtl/win_buf_pkg.sv
// rtl/win_buf_pkg.sv - shared constants and window indexing for the KxK window buffer
package win_buf_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int K_MIN      = 3;
  localparam int K_MAX      = 15;

  // Bit offset of window element (r,c) in the flattened window bus.
  function automatic int idx(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction
endpackage

// File: rtl/window_pos_ctrl.sv
// rtl/window_pos_ctrl.sv - image position counters, valid and frame-done generation
module window_pos_ctrl
  import win_buf_pkg::*;
#(
  parameter int K    = 15,
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o,
  output logic frame_done_o
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          last_col;
  logic          last_row;

  assign last_col = (col_cnt == CW'(COLS - 1));
  assign last_row = (row_cnt == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (flush_i) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (valid_i) begin
      // Window status is judged on the position of the column being accepted.
      valid_o      <= (row_cnt >= RW'(K - 1)) && (col_cnt >= CW'(K - 1));
      frame_done_o <= last_row && last_col;
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end else begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end
  end
endmodule

// File: rtl/window_buffer_nxn.sv
// rtl/window_buffer_nxn.sv - parametrised KxK sliding-window register array
module window_buffer_nxn
  import win_buf_pkg::*;
#(
  parameter int DATA_WIDTH = win_buf_pkg::DATA_WIDTH,
  parameter int K          = 15,
  parameter int COLS       = 640,
  parameter int ROWS       = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        valid_i,
  input  logic [K*DATA_WIDTH-1:0]     col_i,
  output logic [K*K*DATA_WIDTH-1:0]   win_o,
  output logic                        valid_o,
  output logic                        frame_done_o
);
  if ((K % 2) == 0 || K < K_MIN || K > K_MAX || K > COLS || K > ROWS) begin : g_bad_k
    $fatal(1, "window_buffer_nxn: K must be odd, within 3..15 and no larger than COLS/ROWS");
  end

  logic [DATA_WIDTH-1:0] win [K][K];
  logic                  accept;

  assign accept = valid_i && !flush_i;

  for (genvar r = 0; r < K; r++) begin : g_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int c = 0; c < K; c++) win[r][c] <= '0;
      end else if (accept) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_i[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (genvar c = 0; c < K; c++) begin : g_col
      assign win_o[idx(r, c, K, DATA_WIDTH) +: DATA_WIDTH] = win[r][c];
    end
  end

  window_pos_ctrl #(
    .K    (K),
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o)
  );
endmodule

// File: doc/window_buffer_nxn.md
Name: window_buffer_nxn

Overview:
- Parametrised K×K sliding-window register array. Successor to the fixed-size window buffers; one module covers every odd window size from 3 to 15.
- Sits between the line-buffer bank, which supplies one K-tall pixel column per accepted cycle, and the filter/median kernels.
- Adds what the fixed buffers lack:
  - bubble-tolerant valid handshake;
  - gating so that only full in-image windows are flagged;
  - per-frame completion pulse;
  - synchronous flush.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- K, 15, window edge. Must be odd, 3..15, K<=COLS and K<=ROWS; checked at elaboration with a fatal error.
- COLS, 640, image width in pixels.
- ROWS, 480, image height in pixels.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of counters and valid state.
- valid_i  in  1  col_i holds a new column this cycle.
- col_i  in  K*DATA_WIDTH  new column. Slice r (bits r*DW +: DW) is window row r; r=0 is the oldest/top row.
- win_o  out  K*K*DATA_WIDTH  window. Element (r,c) is at index (r*K+c)*DW; c=0 is the oldest/left column.
- valid_o  out  1  win_o is a complete in-image window.
- frame_done_o  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (rst_n low, asynchronous): all window registers, win_o, valid_o, frame_done_o, col_cnt and row_cnt clear to 0 immediately.
- col_cnt (0..COLS-1) and row_cnt (0..ROWS-1) give the image position of the next accepted column.
- Accept on a rising edge when valid_i=1 and flush_i=0:
  - all window columns shift left by one and col_i loads column K-1;
  - col_cnt increments; at COLS-1 it wraps to 0 and row_cnt increments;
  - at (ROWS-1, COLS-1) both counters wrap to 0, ready for the next frame.
- valid_i=0: window, counters and win_o hold; valid_o and frame_done_o are 0 that cycle.
- valid_o is registered, latency 1. It is 1 in the cycle after an accept where row_cnt>=K-1 and col_cnt>=K-1, evaluated before the counter update. Otherwise it is 0.
- Exactly (ROWS-K+1)*(COLS-K+1) valid_o pulses per frame.
- win_o is driven directly from the window registers. Stale columns from the previous row remain after a row wrap but are masked by valid_o until K new columns have arrived.
- frame_done_o: 1 in the cycle after accepting the column at (ROWS-1, COLS-1). Always coincident with valid_o.
- flush_i=1: clears counters, valid_o and frame_done_o on the next edge. Window data is left untouched. flush_i wins over a simultaneous valid_i; that column is discarded.
- Counter widths: $clog2(COLS) and $clog2(ROWS); no overflow past the wrap points.
- The block has no back-pressure input. Downstream must consume each valid_o cycle.

Decomposition:
- Package win_buf_pkg holds:
  - DATA_WIDTH default;
  - K_MIN=3 and K_MAX=15;
  - function idx(r,c) returning (r*K+c)*DW.
- Sub-module window_pos_ctrl holds col_cnt/row_cnt, the valid/frame_done generation and flush handling.
- The top level holds a generate loop of K rows of K-deep shift registers.

Test Plan:
All tests use K=3, COLS=5, ROWS=5, DW=8, and column n carries value n in every row, for n = 1..25.
1. Reset: hold rst_n=0 for 3 cycles with random valid_i/col_i -> win_o=0, valid_o=0, frame_done_o=0 throughout.
2. Continuous stream n=1..25:
   - first valid_o occurs the cycle after n=13 is accepted, with every row = [11,12,13];
   - 9 pulses total;
   - the last has rows [23,24,25] with frame_done_o=1.
3. Same stream with valid_i toggling every cycle -> identical 9 windows and contents. valid_o never asserts in a cycle following a bubble.
4. Two back-to-back frames n=1..25, then 26..50 -> the second frame produces 9 windows, the first being [36,37,38]. There are two frame_done_o pulses, 25 accepts apart.
5. Drop rst_n asynchronously (mid-cycle) after n=17 is accepted -> all outputs are 0 before the next edge. Restarting with n=1 reproduces scenario 2 exactly.
6. Assert flush_i together with valid_i on column n=8 -> column 8 is not shifted in and the counters read 0. Feeding n=1..25 afterwards gives 9 windows as in scenario 2.
